instr_fetch_unit: RTL and testbench

//  Front-end fetch stage that drives the CONSUMER_A port of program_memory_bus.

---
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generation, credit-limited word reads on the program
// memory bus, a shadow pipe tracking the PCs of in-flight reads, and a fetch
// FIFO presenting {instr, pc} to decode over valid/ready.
// Optional feature macro: IFU_PERF_CNT_EN adds the perf_stall_out counter.
module instr_fetch_unit #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        fetch_en_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] mem_addr,
    output logic        mem_read_request,
    input  logic [31:0] mem_instr,
    input  logic        mem_data_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        ready_in
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_out
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + MEM_LATENCY + 2) + 1;
    localparam int unsigned TAIL  = MEM_LATENCY - 1;

    logic [31:0]            pc_q;
    logic [MEM_LATENCY-1:0] shadow_live;
    logic [31:0]            shadow_pc [MEM_LATENCY];
    logic [31:0]            fifo_instr [FIFO_DEPTH];
    logic [31:0]            fifo_pc [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W-1:0]       count_next;
    logic [OCC_W-1:0]       inflight;
    logic [OCC_W-1:0]       occupancy;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic [1:0]             unused_pc_lsb;

    assign unused_pc_lsb = redirect_pc_in[1:0];

    // Credit: the request on the bus plus every live shadow stage is owed a
    // FIFO slot; the head leaving this cycle frees one, which keeps the
    // stream at one word per cycle.
    always_comb begin
        inflight = OCC_W'(mem_read_request);
        for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            inflight = inflight + OCC_W'(shadow_live[i]);
        end
        pop        = valid_out && ready_in;
        push       = mem_data_valid && shadow_live[TAIL] && !redirect_in;
        occupancy  = OCC_W'(fifo_count) + inflight - OCC_W'(pop);
        issue      = fetch_en_in && !redirect_in && (occupancy < OCC_W'(FIFO_DEPTH));
        count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    end

    // PC and registered bus request.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc_q             <= RESET_PC;
            mem_addr         <= RESET_PC;
            mem_read_request <= 1'b0;
        end else if (redirect_in) begin
            pc_q             <= {redirect_pc_in[31:2], 2'b00};
            mem_read_request <= 1'b0;
        end else if (issue) begin
            mem_addr         <= pc_q;
            mem_read_request <= 1'b1;
            pc_q             <= pc_q + 32'd4;
        end else begin
            mem_read_request <= 1'b0;
        end
    end

    // Shadow pipe follows the bus request so its tail lines up with data_valid.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow_live <= '0;
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                shadow_pc[i] <= '0;
            end
        end else begin
            if (redirect_in) begin
                shadow_live <= '0;
            end else begin
                shadow_live[0] <= mem_read_request;
                for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                    shadow_live[i] <= shadow_live[i-1];
                end
            end
            shadow_pc[0] <= mem_addr;
            for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                shadow_pc[i] <= shadow_pc[i-1];
            end
        end
    end

    // FIFO pointers, count and registered valid; redirect flushes.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            valid_out  <= 1'b0;
        end else if (redirect_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            valid_out  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= count_next;
            valid_out  <= (count_next != '0);
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_instr[wr_ptr] <= mem_instr;
            fifo_pc[wr_ptr]    <= shadow_pc[TAIL];
        end
    end

    assign instr_out = fifo_instr[rd_ptr];
    assign pc_out    = fifo_pc[rd_ptr];

`ifdef IFU_PERF_CNT_EN
    // Saturating count of cycles decode is starved while fetch is enabled.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            perf_stall_out <= '0;
        end else if (fetch_en_in && !valid_out && (perf_stall_out != '1)) begin
            perf_stall_out <= perf_stall_out + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    no_push_when_full: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        !(push && (fifo_count == CNT_W'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a latency-accurate memory model, a reference
// stream model (each epoch delivers start_pc, start_pc+4, ... in order) and a
// negedge monitor scoring every bus request and decode handshake.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned LAT    = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] XOR_K  = 32'hA5A5_0000;

    logic        clk_in = 1'b0;
    logic        rst_n_in, fetch_en_in, redirect_in, ready_in;
    logic [31:0] redirect_pc_in;
    logic [31:0] mem_addr, instr_out, pc_out;
    logic        mem_read_request, valid_out;
    logic [31:0] mem_instr = 32'h0;
    logic        mem_data_valid = 1'b0;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_stall_out;
`endif

    int checks = 0;
    int failures = 0;

    instr_fetch_unit #(.FIFO_DEPTH(DEPTH), .MEM_LATENCY(LAT), .RESET_PC(RST_PC)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .fetch_en_in(fetch_en_in),
        .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
        .mem_addr(mem_addr), .mem_read_request(mem_read_request),
        .mem_instr(mem_instr), .mem_data_valid(mem_data_valid),
        .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out),
        .ready_in(ready_in)
`ifdef IFU_PERF_CNT_EN
        , .perf_stall_out(perf_stall_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: answers a request seen in cycle k with data_valid in cycle k+LAT;
    // empty slots sometimes carry junk pulses that must be ignored.
    bit        mv [LAT];
    bit [31:0] ma [LAT];
    always @(posedge clk_in) begin
        #1;
        if (mv[LAT-1]) begin
            mem_data_valid = 1'b1;
            mem_instr      = ma[LAT-1] ^ XOR_K;
        end else if ($urandom_range(0, 7) == 0) begin
            mem_data_valid = 1'b1;
            mem_instr      = $urandom;
        end else begin
            mem_data_valid = 1'b0;
            mem_instr      = 32'h0;
        end
        for (int i = LAT - 1; i > 0; i--) begin
            mv[i] = mv[i-1];
            ma[i] = ma[i-1];
        end
        mv[0] = mem_read_request;
        ma[0] = mem_addr;
    end

    // Reference model and scoreboard.
    logic [31:0] exp_q [$];
    logic [31:0] gen_pc, next_req_pc, held_pc, held_instr, exp_pc, perf_model;
    bit          prev_redirect, prev_hold;
    int          req_cnt, pop_cnt;

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            chk("reset_req", 32'(mem_read_request), 32'd0);
            chk("reset_valid", 32'(valid_out), 32'd0);
            exp_q.delete();
            gen_pc = RST_PC; next_req_pc = RST_PC;
            prev_redirect = 0; prev_hold = 0;
            req_cnt = 0; pop_cnt = 0; perf_model = 0;
        end else begin
            while (exp_q.size() < 8) begin
                exp_q.push_back(gen_pc);
                gen_pc = gen_pc + 32'd4;
            end
            if (prev_redirect) begin
                chk("post_redirect_valid", 32'(valid_out), 32'd0);
                chk("post_redirect_req", 32'(mem_read_request), 32'd0);
            end else if (prev_hold) begin
                chk("hold_valid", 32'(valid_out), 32'd1);
                chk("hold_pc", pc_out, held_pc);
                chk("hold_instr", instr_out, held_instr);
            end
            if (mem_read_request) begin
                chk("req_addr", mem_addr, next_req_pc);
                next_req_pc = next_req_pc + 32'd4;
                req_cnt++;
            end
            if (valid_out && ready_in) begin
                exp_pc = exp_q.pop_front();
                chk("out_pc", pc_out, exp_pc);
                chk("out_instr", instr_out, exp_pc ^ XOR_K);
                pop_cnt++;
            end
`ifdef IFU_PERF_CNT_EN
            chk("perf_stall", perf_stall_out, perf_model);
            if (fetch_en_in && !valid_out && perf_model != 32'hFFFF_FFFF) perf_model++;
`endif
            prev_hold  = valid_out && !ready_in;
            held_pc    = pc_out;
            held_instr = instr_out;
            prev_redirect = redirect_in;
            if (redirect_in) begin
                exp_q.delete();
                gen_pc      = {redirect_pc_in[31:2], 2'b00};
                next_req_pc = gen_pc;
            end
        end
    end

    task automatic cyc();
        @(posedge clk_in); #1;
    endtask

    task automatic apply_reset();
        cyc();
        rst_n_in = 0; fetch_en_in = 0; ready_in = 0; redirect_in = 0;
        cyc(); cyc();
        rst_n_in = 1;
    endtask

    int  first_req, first_valid, n;
    bit  found;

    initial begin
        rst_n_in = 0; fetch_en_in = 0; redirect_in = 0; redirect_pc_in = 0; ready_in = 0;
        #23;
        chk("rst_addr", mem_addr, RST_PC);
        chk("rst_req0", 32'(mem_read_request), 32'd0);
        chk("rst_valid0", 32'(valid_out), 32'd0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_perf", perf_stall_out, 32'd0);
`endif

        // Streaming from reset: request in cycle 1, first valid in cycle 4.
        cyc();
        rst_n_in = 1; fetch_en_in = 1; ready_in = 1;
        first_req = -1; first_valid = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_in);
            if (mem_read_request && first_req < 0) first_req = c;
            if (valid_out && first_valid < 0) first_valid = c;
        end
        chk("first_req_cycle", 32'(first_req), 32'd1);
        chk("first_valid_cycle", 32'(first_valid), 32'd4);
        n = 0;
        repeat (20) begin @(negedge clk_in); if (valid_out) n++; end
        chk("steady_valid_cycles", 32'(n), 32'd20);

        // Decode stalled from cycle 0: exactly DEPTH reads, then resume.
        apply_reset();
        fetch_en_in = 1; ready_in = 0;
        n = 0;
        repeat (15) begin @(negedge clk_in); if (mem_read_request) n++; end
        chk("full_issue_count", 32'(n), 32'(DEPTH));
        chk("full_head_valid", 32'(valid_out), 32'd1);
        chk("full_head_pc", pc_out, RST_PC);
        cyc();
        ready_in = 1;
        repeat (12) cyc();
        chk("resume_after_full", 32'(req_cnt > int'(DEPTH)), 32'd1);

        // Redirect during a steady stream at pc 0x40.
        apply_reset();
        fetch_en_in = 1; ready_in = 1;
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk_in);
            if (valid_out && pc_out == 32'h40) found = 1;
        end
        chk("reach_0x40", 32'(found), 32'd1);
        cyc();
        redirect_in = 1; redirect_pc_in = 32'h200;
        cyc();
        redirect_in = 0;
        first_valid = -1;
        for (int c = 1; c < 20 && first_valid < 0; c++) begin
            @(negedge clk_in);
            if (valid_out) first_valid = c;
        end
        chk("redirect_valid_latency", 32'(first_valid), 32'd5);
        chk("redirect_head_pc", pc_out, 32'h200);

        // Redirect while the FIFO is full and decode is stalled.
        cyc();
        ready_in = 0;
        repeat (12) cyc();
        chk("full2_valid", 32'(valid_out), 32'd1);
        redirect_in = 1; redirect_pc_in = 32'h301;
        cyc();
        redirect_in = 0;
        @(negedge clk_in);
        chk("flush_empty", 32'(valid_out), 32'd0);
        first_req = -1;
        for (int c = 1; c < 10 && first_req < 0; c++) begin
            if (c > 1) @(negedge clk_in);
            if (mem_read_request) begin first_req = c; chk("flush_first_addr", mem_addr, 32'h300); end
        end
        chk("flush_first_req_cycle", 32'(first_req), 32'd2);
        cyc();
        ready_in = 1;
        repeat (15) cyc();

        // fetch_en drop mid-stream: in-flight reads land, FIFO drains.
        apply_reset();
        fetch_en_in = 1; ready_in = 1;
        repeat (10) cyc();
        fetch_en_in = 0;
        @(negedge clk_in);
        n = 0;
        repeat (12) begin @(negedge clk_in); if (mem_read_request) n++; end
        chk("no_req_after_disable", 32'(n), 32'd0);
        chk("drained_valid", 32'(valid_out), 32'd0);
        chk("all_reads_landed", 32'(pop_cnt), 32'(req_cnt));
`ifdef IFU_PERF_CNT_EN
        chk("perf_idle_cycles", perf_stall_out, 32'd4);
`endif

        // Asynchronous reset between edges.
        apply_reset();
        fetch_en_in = 1; ready_in = 1;
        repeat (10) cyc();
        @(negedge clk_in);
        chk("pre_async_valid", 32'(valid_out), 32'd1);
        @(posedge clk_in); #3;
        rst_n_in = 0;
        #1;
        chk("async_req_low", 32'(mem_read_request), 32'd0);
        chk("async_valid_low", 32'(valid_out), 32'd0);
`ifdef IFU_PERF_CNT_EN
        chk("async_perf_zero", perf_stall_out, 32'd0);
`endif
        cyc(); cyc(); cyc();
        rst_n_in = 1;
        found = 0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk_in);
            if (mem_read_request) begin found = 1; chk("restart_addr", mem_addr, RST_PC); end
        end
        chk("restart_seen", 32'(found), 32'd1);

        // Randomized traffic, including redirects near the top of the address space.
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            cyc();
            fetch_en_in    = ($urandom_range(0, 7) != 0);
            ready_in       = ($urandom_range(0, 3) != 0);
            redirect_in    = ($urandom_range(0, 19) == 0);
            redirect_pc_in = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
        end
        cyc();
        redirect_in = 0; fetch_en_in = 1; ready_in = 1;
        repeat (20) cyc();
        chk("random_progress", 32'(pop_cnt > 0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
